// File: rtl/pbkdf2_f_ctrl_if.sv
// Job, derived-key and HMAC-engine handshake bundle for pbkdf2_f_ctrl.
// master = the controller, slave = its environment.
interface pbkdf2_f_ctrl_if #(
  parameter int WIDTH_P      = 256,
  parameter int ITER_WIDTH_P = 32
);
  logic                    v_i;
  logic                    r_o;
  logic [WIDTH_P-1:0]      prf_i;
  logic [WIDTH_P-1:0]      salt_i;
  logic [ITER_WIDTH_P-1:0] iter_i;
  logic                    v_o;
  logic                    r_i;
  logic [WIDTH_P-1:0]      dk_o;
  logic                    hmac_v_o;
  logic                    hmac_r_i;
  logic [WIDTH_P-1:0]      hmac_key_o;
  logic [WIDTH_P-1:0]      hmac_msg_o;
  logic                    hmac_v_i;
  logic [WIDTH_P-1:0]      hmac_prf_i;
  logic                    hmac_yumi_o;

  modport master (
    input  v_i, prf_i, salt_i, iter_i, r_i,
    input  hmac_r_i, hmac_v_i, hmac_prf_i,
    output r_o, v_o, dk_o,
    output hmac_v_o, hmac_key_o, hmac_msg_o, hmac_yumi_o
  );

  modport slave (
    output v_i, prf_i, salt_i, iter_i, r_i,
    output hmac_r_i, hmac_v_i, hmac_prf_i,
    input  r_o, v_o, dk_o,
    input  hmac_v_o, hmac_key_o, hmac_msg_o, hmac_yumi_o
  );
endinterface

// File: rtl/pbkdf2_f_ctrl.sv
// PBKDF2 F-function sequencer: T = U1 ^ ... ^ Uc via an external HMAC engine.
// Defining PBKDF2_ABORT_EN adds the abort_i port and the DRAIN state.
module pbkdf2_f_ctrl #(
  parameter int WIDTH_P      = 256,
  parameter int ITER_WIDTH_P = 32
) (
  input logic             clk_i,
  input logic             rst_i,
`ifdef PBKDF2_ABORT_EN
  input logic             abort_i,
`endif
  pbkdf2_f_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DONE, DRAIN
  } state_e;

  localparam logic [ITER_WIDTH_P-1:0] ONE =
    ITER_WIDTH_P'(1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [WIDTH_P-1:0]      r_key;
  logic [WIDTH_P-1:0]      r_salt;
  logic [WIDTH_P-1:0]      r_u;
  logic [WIDTH_P-1:0]      r_acc;
  logic [ITER_WIDTH_P-1:0] r_cnt;
  logic                    r_first;
  logic                    w_accept;
  logic                    w_consume;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_consume   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.v_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.hmac_r_i) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.hmac_v_i) begin
          w_consume   = 1'b1;
          w_state_nxt = (r_cnt == ONE) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (bus.r_i) w_state_nxt = IDLE;
      end
      DRAIN: begin
        if (bus.hmac_v_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef PBKDF2_ABORT_EN
    // A request accepted in the abort cycle is still owed a result: drain it.
    if (abort_i) begin
      unique case (r_state)
        ISSUE: w_state_nxt = bus.hmac_r_i ? DRAIN : IDLE;
        WAIT: begin
          w_consume   = 1'b0;
          w_state_nxt = bus.hmac_v_i ? IDLE : DRAIN;
        end
        DONE:    w_state_nxt = IDLE;
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_key   <= '0;
      r_salt  <= '0;
      r_u     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      if (w_accept) begin
        r_key   <= bus.prf_i;
        r_salt  <= bus.salt_i;
        r_cnt   <= (bus.iter_i == '0) ? ONE : bus.iter_i;
        r_first <= 1'b1;
      end
      if (w_consume) begin
        r_u     <= bus.hmac_prf_i;
        r_acc   <= r_first ? bus.hmac_prf_i
                           : r_acc ^ bus.hmac_prf_i;
        r_cnt   <= r_cnt - ONE;
        r_first <= 1'b0;
      end
    end
  end

  assign bus.r_o         = (r_state == IDLE);
  assign bus.v_o         = (r_state == DONE);
  assign bus.dk_o        = r_acc;
  assign bus.hmac_v_o    = (r_state == ISSUE);
  assign bus.hmac_key_o  = r_key;
  assign bus.hmac_msg_o  = r_first ? r_salt : r_u;
  assign bus.hmac_yumi_o = bus.hmac_v_i &
    ((r_state == WAIT) || (r_state == DRAIN));
endmodule

// File: tb/tb_pbkdf2_f_ctrl.sv
// Scoreboard bench for pbkdf2_f_ctrl with an msg+1, 3-cycle HMAC stub.
// Build with +define+PBKDF2_ABORT_EN to add the abort scenario.
`timescale 1ns/1ps
module tb_pbkdf2_f_ctrl;
  localparam int W  = 256;
  localparam int IW = 8;
  localparam int L  = 3;
  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t dk;
    int    c;
    int    acc_cyc;
    int    rhold;
    bit    lat_chk;
  } exp_t;

  logic  clk_i = 1'b0;
  logic  rst_i = 1'b1;
`ifdef PBKDF2_ABORT_EN
  logic  abort_i = 1'b0;
`endif
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  exp_t  q[$];
  word_t cur_salt = '0;
  word_t cur_key = '0;
  int    hs_total = 0;
  int    hs_base = 0;
  bit    stall_en = 1'b0;

  pbkdf2_f_ctrl_if #(.WIDTH_P(W), .ITER_WIDTH_P(IW)) bus ();

  pbkdf2_f_ctrl #(.WIDTH_P(W), .ITER_WIDTH_P(IW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
`ifdef PBKDF2_ABORT_EN
    .abort_i (abort_i),
`endif
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string n, input word_t got, input word_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // T = XOR over k=1..c of (salt + k): the stub makes U_k = salt + k.
  function automatic word_t model_dk(input word_t s, input int c);
    word_t t = '0;
    for (int k = 1; k <= c; k++) t ^= s + word_t'(k);
    return t;
  endfunction

  // HMAC stub: one request at a time, result L cycles after acceptance.
  logic  busy;
  logic  rdy_q;
  int    dly;
  word_t res;
  assign bus.hmac_r_i = !busy && rdy_q;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy           <= 1'b0;
      rdy_q          <= 1'b1;
      dly            <= 0;
      res            <= '0;
      bus.hmac_v_i   <= 1'b0;
      bus.hmac_prf_i <= '0;
    end else begin
      rdy_q <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.hmac_v_o && bus.hmac_r_i) begin
        busy           <= 1'b1;
        dly            <= L;
        res            <= bus.hmac_msg_o + word_t'(1);
        hs_total       <= hs_total + 1;
        bus.hmac_prf_i <= {8{$urandom}};
      end else if (busy && dly > 1) begin
        dly <= dly - 1;
      end else if (busy && dly == 1) begin
        dly            <= 0;
        bus.hmac_v_i   <= 1'b1;
        bus.hmac_prf_i <= res;
      end else if (bus.hmac_v_i && bus.hmac_yumi_o) begin
        bus.hmac_v_i <= 1'b0;
        busy         <= 1'b0;
      end
    end
  end

  // Request-side checks: content, stability under stall, one outstanding.
  bit    prev_stall = 1'b0;
  word_t prev_key, prev_msg;
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.hmac_v_o) begin
        chk("hmac_single_outstanding", word_t'(busy), word_t'(0));
        if (prev_stall) begin
          chk("hmac_key_stable", bus.hmac_key_o, prev_key);
          chk("hmac_msg_stable", bus.hmac_msg_o, prev_msg);
        end
        if (bus.hmac_r_i) begin
          chk("hmac_key", bus.hmac_key_o, cur_key);
          chk("hmac_msg", bus.hmac_msg_o,
              cur_salt + word_t'(hs_total - hs_base));
        end
      end
      prev_stall = bus.hmac_v_o && !bus.hmac_r_i;
      prev_key   = bus.hmac_key_o;
      prev_msg   = bus.hmac_msg_o;
    end
  end

  // Result monitor / downstream: holds r_i low e.rhold cycles, then pops.
  exp_t  e;
  bit    vseen = 1'b0;
  bit    ack_last = 1'b0;
  int    hold = 0;
  word_t first_dk;
  always @(negedge clk_i) begin
    if (rst_i) begin
      vseen    = 1'b0;
      ack_last = 1'b0;
      hold     = 0;
      bus.r_i  = 1'b0;
    end else begin
      if (ack_last) begin
        chk("idle_after_ack_r_o", word_t'(bus.r_o), word_t'(1));
        chk("idle_after_ack_v_o", word_t'(bus.v_o), word_t'(0));
        ack_last = 1'b0;
      end
      if (bus.v_o) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_v_o: got v_o=1 expected no result");
          bus.r_i = 1'b1;
        end else begin
          e = q[0];
          if (!vseen) begin
            vseen    = 1'b1;
            hold     = 0;
            first_dk = bus.dk_o;
            if (e.lat_chk)
              chk("latency", word_t'(cyc - e.acc_cyc),
                  word_t'(1 + e.c * (2 + L)));
          end else begin
            chk("dk_held_stable", bus.dk_o, first_dk);
          end
          if (hold >= e.rhold) begin
            chk("dk", bus.dk_o, e.dk);
            chk("hmac_handshakes", word_t'(hs_total - hs_base),
                word_t'(e.c));
            void'(q.pop_front());
            vseen    = 1'b0;
            ack_last = 1'b1;
            bus.r_i  = 1'b1;
          end else begin
            hold++;
            bus.r_i = 1'b0;
          end
        end
      end else begin
        if (vseen) begin
          chk("v_o_held", word_t'(bus.v_o), word_t'(1));
          vseen = 1'b0;
        end
        bus.r_i = 1'b0;
      end
    end
  end

  task automatic run_job(input word_t s, input int it, input int rh);
    int   g = 0;
    exp_t x;
    @(negedge clk_i);
    while (!bus.r_o && g < 5000) begin
      @(negedge clk_i);
      g++;
    end
    tests++;
    if (!bus.r_o) begin
      fails++;
      $display("FAIL r_o_timeout: got r_o=0 expected 1");
      return;
    end
    x.c       = (it == 0) ? 1 : it;
    x.dk      = model_dk(s, x.c);
    x.acc_cyc = cyc;
    x.rhold   = rh;
    x.lat_chk = !stall_en;
    cur_salt  = s;
    cur_key   = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
    hs_base   = hs_total;
    q.push_back(x);
    bus.v_i    = 1'b1;
    bus.prf_i  = cur_key;
    bus.salt_i = s;
    bus.iter_i = IW'(it);
    @(negedge clk_i);
    bus.v_i    = 1'b0;
    bus.prf_i  = {8{$urandom}};
    bus.salt_i = {8{$urandom}};
  endtask

  task automatic wait_done();
    int g = 0;
    while ((q.size() != 0 || !bus.r_o) && g < 5000) begin
      @(negedge clk_i);
      g++;
    end
    tests++;
    if (g >= 5000) begin
      fails++;
      $display("FAIL done_timeout: got pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_in_wait();
    int g = 0;
    while ((hs_total - hs_base) < 1 && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    tests++;
    if (g >= 100) begin
      fails++;
      $display("FAIL wait_state_timeout: got handshakes=0 expected 1");
    end
  endtask

  initial begin
    word_t s;
    int    ny, nv;
    bus.v_i    = 1'b0;
    bus.prf_i  = '0;
    bus.salt_i = '0;
    bus.iter_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_r_o", word_t'(bus.r_o), word_t'(1));
    chk("rst_v_o", word_t'(bus.v_o), word_t'(0));
    chk("rst_hmac_v_o", word_t'(bus.hmac_v_o), word_t'(0));
    chk("rst_yumi", word_t'(bus.hmac_yumi_o), word_t'(0));
    chk("rst_dk", bus.dk_o, '0);
    rst_i = 1'b0;

    run_job('0, 1, 0);  wait_done();
    run_job('0, 3, 0);  wait_done();
    run_job(word_t'(5), 0, 0);  wait_done();
    run_job('0, 2, 10); wait_done();

    run_job('0, 4, 0);
    wait_in_wait();
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_r_o", word_t'(bus.r_o), word_t'(1));
    chk("midrst_v_o", word_t'(bus.v_o), word_t'(0));
    chk("midrst_hmac_v_o", word_t'(bus.hmac_v_o), word_t'(0));
    chk("midrst_yumi", word_t'(bus.hmac_yumi_o), word_t'(0));
    chk("midrst_dk", bus.dk_o, '0);
    q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    run_job('0, 2, 0); wait_done();

`ifdef PBKDF2_ABORT_EN
    run_job('0, 4, 0);
    wait_in_wait();
    q.delete();
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    ny = 0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.hmac_yumi_o) ny++;
      if (bus.v_o) nv++;
      @(negedge clk_i);
    end
    chk("abort_yumi_pulses", word_t'(ny), word_t'(1));
    chk("abort_no_v_o", word_t'(nv), word_t'(0));
    chk("abort_r_o", word_t'(bus.r_o), word_t'(1));
    run_job(word_t'(9), 2, 0); wait_done();
`endif

    run_job(word_t'(3), (1 << IW) - 1, 1); wait_done();

    stall_en = 1'b1;
    repeat (40) begin
      for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0)
        s = '1 - word_t'($urandom_range(0, 3));
      run_job(s, $urandom_range(0, 6), $urandom_range(0, 3));
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pbkdf2_f_ctrl.md
PBKDF2_F_CTRL -- requirements
Module: pbkdf2_f_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_P, default 256, the bit width of the key, salt, U-block and derived-key buses.
REQ-002 SHALL have parameter ITER_WIDTH_P, default 32, the bit width of the iteration-count input.
REQ-003 SHALL have one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 v_i  input  1  upstream job valid.
REQ-007 r_o  output  1  ready to accept a job.
REQ-008 prf_i  input  WIDTH_P  HMAC key (password).
REQ-009 salt_i  input  WIDTH_P  first-iteration message (salt with block index already appended).
REQ-010 iter_i  input  ITER_WIDTH_P  iteration count c.
REQ-011 v_o  output  1  derived block valid.
REQ-012 r_i  input  1  downstream accepts the derived block.
REQ-013 dk_o  output  WIDTH_P  derived block T = U1 ^ ... ^ Uc.
REQ-014 hmac_v_o  output  1  request valid to the HMAC engine.
REQ-015 hmac_r_i  input  1  HMAC engine ready.
REQ-016 hmac_key_o  output  WIDTH_P  HMAC key.
REQ-017 hmac_msg_o  output  WIDTH_P  HMAC message.
REQ-018 hmac_v_i  input  1  HMAC result valid.
REQ-019 hmac_prf_i  input  WIDTH_P  HMAC result.
REQ-020 hmac_yumi_o  output  1  result consumed.
REQ-021 abort_i  input  1  cancel the current job; present only when PBKDF2_ABORT_EN is defined.

Function
REQ-022 SHALL implement the states IDLE, ISSUE, WAIT, DONE and DRAIN.
REQ-023 r_o SHALL be 1 only in IDLE.
REQ-024 On v_i & r_o, SHALL register prf_i, salt_i and cnt = max(iter_i, 1), and SHALL enter ISSUE.
- iter_i = 0 is treated as c = 1.
REQ-025 In ISSUE, SHALL drive hmac_v_o = 1 and hmac_key_o = the registered key.
- hmac_msg_o = the registered salt on the first iteration, otherwise u_r (the previous U).
- On hmac_r_i, SHALL enter WAIT.
REQ-026 hmac_key_o and hmac_msg_o SHALL stay stable while hmac_v_o & ~hmac_r_i.
REQ-027 In WAIT, SHALL drive hmac_yumi_o = hmac_v_i.
- On a consumed result: u_r <= hmac_prf_i.
- acc <= hmac_prf_i on the first iteration, otherwise acc ^ hmac_prf_i.
- cnt decrements.
- Next state is DONE if cnt was 1, otherwise ISSUE.
REQ-028 At most one HMAC request SHALL be outstanding at any time.
REQ-029 In DONE, SHALL drive v_o = 1 and dk_o = acc, and SHALL hold both stable until r_i.
- On v_o & r_i, SHALL enter IDLE.
- A new job is not accepted in that same cycle.
REQ-030 dk_o SHALL equal acc in every state.
- Its value is meaningful only while v_o = 1.
REQ-031 Minimum job latency SHALL be 1 + c*(2 + L) cycles from acceptance to v_o, where L is the engine response latency.
REQ-032 The iteration counter SHALL be ITER_WIDTH_P bits and SHALL not wrap.
- An iteration count of 2^ITER_WIDTH_P-1 SHALL complete exactly that many iterations.

Reset
REQ-033 rst_i SHALL force the following immediately, at any time including mid-job:
- state to IDLE;
- cnt, acc and u_r to 0;
- r_o to 1;
- v_o, hmac_v_o and hmac_yumi_o to 0.
REQ-034 After reset is released, SHALL accept a job on the first clock edge with v_i = 1.

Configuration
REQ-035 With PBKDF2_ABORT_EN defined, abort_i SHALL behave as follows:
- In ISSUE or DONE, abort_i = 1 returns to IDLE on the next edge, and no result is produced.
- In WAIT, abort_i = 1 enters DRAIN.
- In DRAIN, the FSM SHALL assert hmac_yumi_o = hmac_v_i, discard the result, and then enter IDLE.
- abort_i in IDLE SHALL be ignored.
- abort_i in DRAIN SHALL have no further effect.
REQ-036 Without PBKDF2_ABORT_EN, the abort_i port SHALL be absent and the DRAIN state SHALL be unreachable or removed.

Verification
REQ-037 The bench SHALL use a stub HMAC engine returning msg+1 (mod 2^WIDTH_P) with a 3-cycle latency, and SHALL cover the following scenarios:
- salt=0, iter=1 -> dk_o = 1; v_o rises 6 cycles after acceptance.
- salt=0, iter=3 -> U = 1, 2, 3; dk_o = 0; exactly 3 hmac handshakes.
- salt=5, iter=0 -> treated as c=1; dk_o = 6.
- salt=0, iter=2, r_i held 0 for 10 cycles -> v_o = 1 and dk_o = 3 held stable; IDLE the cycle after r_i.
- rst_i asserted while in WAIT with iter=4 -> all outputs reach their reset values at once; the next job salt=0, iter=2 gives dk_o = 3.
- PBKDF2_ABORT_EN defined, abort_i pulsed in WAIT -> one hmac_yumi_o pulse, no v_o, r_o = 1 afterward.
